// File: rtl/turbo_enc_siso_buf_if.sv
// Symbol bus between the SISO address generator, the frame buffer and the
// constituent encoder.
//   i_siso_buf_wr / i_siso_data_ab : write strobe and symbol pair {a,b} into the buffer
//   o_enc_valid / o_enc_data_ab / o_enc_last / i_enc_ready : valid/ready stream to the encoder
// The master modport is the environment side (address generator plus encoder);
// the slave modport is the buffer itself.
interface turbo_enc_siso_buf_if;
    logic       i_siso_buf_wr;
    logic [1:0] i_siso_data_ab;
    logic       o_enc_valid;
    logic [1:0] o_enc_data_ab;
    logic       o_enc_last;
    logic       i_enc_ready;

    modport master (
        output i_siso_buf_wr, i_siso_data_ab, i_enc_ready,
        input  o_enc_valid, o_enc_data_ab, o_enc_last
    );

    modport slave (
        input  i_siso_buf_wr, i_siso_data_ab, i_enc_ready,
        output o_enc_valid, o_enc_data_ab, o_enc_last
    );
endinterface

// File: rtl/turbo_enc_siso_buf.sv
// Frame buffer between the SISO address generator and the turbo constituent
// encoder. One frame of symbol pairs is collected (FILL) and then streamed out
// in write order over a valid/ready handshake (DRAIN).
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start, i_ea  : open a frame whose last symbol index is i_ea
//   bus            : write strobe/data in, encoder stream out (turbo_enc_siso_buf_if.slave)
//   o_busy         : high whenever the buffer is not idle
//   o_frame_done   : one-cycle pulse after the last symbol is accepted
//   o_wr_err       : sticky dropped-write flag, present only with
//                    `define TURBO_ENC_SISO_BUF_WR_ERR_EN
module turbo_enc_siso_buf #(
    parameter int unsigned MAX_BLOCK_WIDTH = 10,
    parameter int unsigned MAX_DATA_WIDTH  = MAX_BLOCK_WIDTH + 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [MAX_DATA_WIDTH-1:0] i_ea,
    turbo_enc_siso_buf_if.slave       bus,
    output logic                      o_busy,
`ifdef TURBO_ENC_SISO_BUF_WR_ERR_EN
    output logic                      o_wr_err,
`endif
    output logic                      o_frame_done
);
    localparam int unsigned AW    = MAX_DATA_WIDTH;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ea_q, ea_d;
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]   rd_next_c;
    logic            valid_q, valid_d;
    logic [1:0]      data_q, data_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wr_en_c;

    logic [1:0]      mem [DEPTH];

    // Symbol storage; no reset needed.
    always_ff @(posedge i_clk) begin
        if (wr_en_c && !i_rst) begin
            mem[wr_cnt_q] <= bus.i_siso_data_ab;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        ea_d      = ea_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        done_d    = 1'b0;
        wr_en_c   = 1'b0;
        rd_next_c = rd_cnt_q + AW'(1);

        if (i_start) begin
            // A start in any state (re)opens a frame; any frame in flight is abandoned.
            state_d  = S_FILL;
            ea_d     = i_ea;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_FILL: begin
                    if (bus.i_siso_buf_wr) begin
                        wr_en_c = 1'b1;
                        // Counter stops on the final write so a full-depth frame never wraps.
                        if (wr_cnt_q == ea_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            wr_cnt_d = wr_cnt_q + AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!valid_q) begin
                        // First presentation: load output register from the head of the frame.
                        valid_d = 1'b1;
                        data_d  = mem[rd_cnt_q];
                        last_d  = (rd_cnt_q == ea_q);
                    end else if (bus.i_enc_ready) begin
                        if (last_q) begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            // Pre-fetch the next symbol so transfers run one per cycle.
                            rd_cnt_d = rd_next_c;
                            data_d   = mem[rd_next_c];
                            last_d   = (rd_next_c == ea_q);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            ea_q     <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= 2'b00;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ea_q     <= ea_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef TURBO_ENC_SISO_BUF_WR_ERR_EN
    logic wr_err_q, wr_err_d;
    logic drop_c;

    // A write is dropped whenever it is not accepted into FILL storage.
    assign drop_c = bus.i_siso_buf_wr && (i_start || (state_q != S_FILL));

    // Start clears the flag, but a write dropped in the same cycle still sets it.
    always_comb begin
        wr_err_d = (i_start ? 1'b0 : wr_err_q) | drop_c;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign o_wr_err = wr_err_q;
`endif

    assign bus.o_enc_valid   = valid_q;
    assign bus.o_enc_data_ab = data_q;
    assign bus.o_enc_last    = last_q;
    assign o_busy            = busy_q;
    assign o_frame_done      = done_q;

endmodule

// File: tb/tb_turbo_enc_siso_buf.sv
// Scoreboard bench for turbo_enc_siso_buf: expected {last,data} entries are
// queued as symbols are written and popped on every encoder-side transfer.
module tb_turbo_enc_siso_buf;
    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] ea;
    logic        busy;
    logic        frame_done;
`ifdef TURBO_ENC_SISO_BUF_WR_ERR_EN
    logic        wr_err;
`endif

    turbo_enc_siso_buf_if bus_if ();

    turbo_enc_siso_buf dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_ea         (ea),
        .bus          (bus_if.slave),
        .o_busy       (busy),
`ifdef TURBO_ENC_SISO_BUF_WR_ERR_EN
        .o_wr_err     (wr_err),
`endif
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int frames_done = 0;
    int valid_cycles = 0;
    logic [2:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: scoreboard compare, stall stability and done timing.
    logic       prev_stall = 1'b0;
    logic       prev_xfer_last = 1'b0;
    logic [1:0] prev_data = 2'b00;
    logic       prev_last = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall     = 1'b0;
            prev_xfer_last = 1'b0;
        end else begin
            logic [2:0] exp_e;
            check("done_timing", 32'(frame_done), 32'(prev_xfer_last));
            if (frame_done) frames_done++;
            if (prev_stall) begin
                check("stall_valid", 32'(bus_if.o_enc_valid), 32'd1);
                check("stall_data", 32'(bus_if.o_enc_data_ab), 32'(prev_data));
                check("stall_last", 32'(bus_if.o_enc_last), 32'(prev_last));
            end
            if (bus_if.o_enc_valid) valid_cycles++;
            if (bus_if.o_enc_valid && bus_if.i_enc_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    check("out_data", 32'(bus_if.o_enc_data_ab), 32'(exp_e[1:0]));
                    check("out_last", 32'(bus_if.o_enc_last), 32'(exp_e[2]));
                end
            end
            prev_xfer_last = bus_if.o_enc_valid && bus_if.i_enc_ready && bus_if.o_enc_last;
            prev_stall     = bus_if.o_enc_valid && !bus_if.i_enc_ready;
            prev_data      = bus_if.o_enc_data_ab;
            prev_last      = bus_if.o_enc_last;
        end
    end

    task automatic open_frame(input int e);
        start = 1'b1;
        ea    = 12'(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic write_sym(input logic [1:0] d);
        bus_if.i_siso_buf_wr  = 1'b1;
        bus_if.i_siso_data_ab = d;
        @(posedge clk); #1;
        bus_if.i_siso_buf_wr  = 1'b0;
    endtask

    // Write symbols and queue their expected outputs (last flag on index e).
    task automatic fill(input int e, input logic [1:0] d [$]);
        for (int i = 0; i < d.size(); i++) begin
            sb.push_back({(i == e), d[i]});
            write_sym(d[i]);
        end
    endtask

    // Drive ready (mode 0: held high, mode 1: pattern 1,0,0,1) until one more frame completes.
    task automatic drain(input int mode);
        int target;
        logic [3:0] ptn;
        target = frames_done + 1;
        ptn = 4'b1001;
        for (int c = 0; c < 20000; c++) begin
            bus_if.i_enc_ready = (mode == 0) ? 1'b1 : ptn[c % 4];
            @(posedge clk); #1;
            if (frames_done >= target) break;
        end
        bus_if.i_enc_ready = 1'b0;
        check("drain_done", 32'(frames_done), 32'(target));
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [1:0] d [$];
        rst = 1'b1;
        start = 1'b0;
        ea = '0;
        bus_if.i_siso_buf_wr  = 1'b0;
        bus_if.i_siso_data_ab = 2'b00;
        bus_if.i_enc_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus_if.o_enc_valid), 32'd0);
        check("rst_data", 32'(bus_if.o_enc_data_ab), 32'd0);
        check("rst_last", 32'(bus_if.o_enc_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
`ifdef TURBO_ENC_SISO_BUF_WR_ERR_EN
        check("rst_wr_err", 32'(wr_err), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Eight symbols, ready held high: one transfer per cycle.
        open_frame(7);
        check("fill_busy", 32'(busy), 32'd1);
        d = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        fill(7, d);
        valid_cycles = 0;
        drain(0);
        check("b2b_cycles", 32'(valid_cycles), 32'd8);

        // Stalling encoder.
        open_frame(3);
        d = '{2'd2, 2'd1, 2'd3, 2'd0};
        fill(3, d);
        drain(1);

        // Single-symbol frame.
        open_frame(0);
        d = '{2'd3};
        fill(0, d);
        drain(0);
        check("single_busy", 32'(busy), 32'd0);

        // Abort mid-fill; only the second frame reaches the encoder.
        open_frame(5);
        d = '{2'd3, 2'd3, 2'd3};
        fill(5, d);
        sb.delete();
        open_frame(1);
        check("abort_valid", 32'(bus_if.o_enc_valid), 32'd0);
        d = '{2'd1, 2'd2};
        fill(1, d);
        drain(0);

        // Write while idle is dropped.
        write_sym(2'd1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_wr_valid", 32'(bus_if.o_enc_valid), 32'd0);
        check("idle_wr_busy", 32'(busy), 32'd0);
`ifdef TURBO_ENC_SISO_BUF_WR_ERR_EN
        check("wr_err_sticky", 32'(wr_err), 32'd1);
`endif
        // Write coincident with start is dropped.
        start = 1'b1;
        ea = 12'd1;
        bus_if.i_siso_buf_wr  = 1'b1;
        bus_if.i_siso_data_ab = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        bus_if.i_siso_buf_wr = 1'b0;
        d = '{2'd1, 2'd2};
        fill(1, d);
        drain(0);
`ifdef TURBO_ENC_SISO_BUF_WR_ERR_EN
        open_frame(0);
        check("wr_err_clear", 32'(wr_err), 32'd0);
        d = '{2'd2};
        fill(0, d);
        drain(0);
`endif

        // Full-depth frame, reset during drain.
        open_frame(4095);
        d.delete();
        for (int i = 0; i < 4096; i++) d.push_back(2'($urandom_range(0, 3)));
        fill(4095, d);
        bus_if.i_enc_ready = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check("mid_rst_valid", 32'(bus_if.o_enc_valid), 32'd0);
        check("mid_rst_data", 32'(bus_if.o_enc_data_ab), 32'd0);
        check("mid_rst_last", 32'(bus_if.o_enc_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        bus_if.i_enc_ready = 1'b0;
        @(posedge clk); #1;

        // Recovery after reset.
        open_frame(1);
        d = '{2'd3, 2'd2};
        fill(1, d);
        drain(0);
`ifdef TURBO_ENC_SISO_BUF_WR_ERR_EN
        check("frame_count", 32'(frames_done), 32'd7);
`else
        check("frame_count", 32'(frames_done), 32'd6);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/turbo_enc_siso_buf.md
TURBO_ENC_SISO_BUF -- requirements
Module: turbo_enc_siso_buf

Interface
REQ-001 SHALL have parameter MAX_BLOCK_WIDTH, default 10, the block-size field width.
REQ-002 SHALL have parameter MAX_DATA_WIDTH, default MAX_BLOCK_WIDTH+2, the symbol address width; storage depth is 2^MAX_DATA_WIDTH entries of 2 bits.
REQ-003 i_clk  input  1  sole clock; all logic on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_start  input  1  one-cycle pulse that opens a new frame.
REQ-006 i_ea  input  MAX_DATA_WIDTH  last symbol index of the frame (frame length = i_ea+1); sampled on i_start.
REQ-007 i_siso_buf_wr  input  1  write strobe from the address generator.
REQ-008 i_siso_data_ab  input  2  symbol pair {a,b}, valid with i_siso_buf_wr.
REQ-009 o_enc_valid  output  1  output symbol valid.
REQ-010 o_enc_data_ab  output  2  symbol pair to the constituent encoder.
REQ-011 o_enc_last  output  1  marks the final symbol, qualified by o_enc_valid.
REQ-012 i_enc_ready  input  1  encoder accepts the symbol.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_frame_done  output  1  one-cycle pulse, registered, in the cycle after the last symbol is accepted.

Function
REQ-015 SHALL implement the FSM IDLE -> FILL -> DRAIN -> IDLE.
REQ-016 IDLE: on i_start, latch i_ea, clear wr_cnt and rd_cnt, and go to FILL.
REQ-017 FILL: on each i_siso_buf_wr, store i_siso_data_ab at mem[wr_cnt] and increment wr_cnt.
REQ-018 FILL: on the write with wr_cnt == ea_q, go to DRAIN on the next cycle.
REQ-019 Frame completion is decided by the write count alone; no separate end-of-read input is used.
REQ-020 DRAIN: o_enc_valid asserts no later than 2 cycles after DRAIN entry; o_enc_data_ab = mem[rd_cnt], output registered.
REQ-021 Transfer occurs when o_enc_valid && i_enc_ready; rd_cnt then increments and the next symbol is presented in the following cycle.
REQ-022 While o_enc_valid && !i_enc_ready, o_enc_data_ab and o_enc_last SHALL hold stable.
REQ-023 o_enc_valid SHALL NOT drop before a transfer occurs.
REQ-024 o_enc_last = 1 exactly when the presented symbol index == ea_q.
REQ-025 On transfer of the last symbol: go to IDLE, deassert o_enc_valid the next cycle, and pulse o_frame_done.
REQ-026 Back-to-back transfers SHALL sustain 1 symbol/cycle with i_enc_ready held high.
REQ-027 i_siso_buf_wr in IDLE or DRAIN SHALL be dropped; memory and counters unchanged.
REQ-028 i_start in FILL or DRAIN SHALL abort the current frame: counters cleared, o_enc_valid low next cycle, no o_frame_done, new i_ea latched, state FILL.
REQ-029 A write coincident with i_start SHALL be dropped.
REQ-030 ea_q = 0 SHALL give a single-symbol frame with o_enc_last set on that symbol.
REQ-031 ea_q = 2^MAX_DATA_WIDTH-1 SHALL use the full memory; counters SHALL NOT wrap mid-frame.

Reset
REQ-032 While i_rst is high: state IDLE, counters 0, ea_q 0.
REQ-033 Reset values: o_enc_valid 0, o_enc_data_ab 0, o_enc_last 0, o_busy 0, o_frame_done 0 (plus o_wr_err 0 when present).
REQ-034 Memory contents need no reset.
REQ-035 Reset asserted mid-frame SHALL discard the frame with no o_frame_done pulse.

Configuration
REQ-036 Macro TURBO_ENC_SISO_BUF_WR_ERR_EN: when defined, adds output o_wr_err (1 bit).
REQ-037 o_wr_err SHALL be a sticky flag set by any write dropped under REQ-027 or REQ-029, and cleared only by i_rst or i_start.
REQ-038 Without TURBO_ENC_SISO_BUF_WR_ERR_EN, the port and its logic SHALL be absent and dropped writes are silent.

Verification
REQ-039 i_start with i_ea=7; 8 writes of 0,1,2,3,0,1,2,3; ready held high -> 8 outputs in order, last on the 8th, o_frame_done 1 cycle after.
REQ-040 i_ea=3, data 2,1,3,0; i_enc_ready toggling 1,0,0,1,... -> data held during stalls, order 2,1,3,0, o_enc_last on the 0.
REQ-041 i_ea=0, single write of 3 -> one output of 3 with o_enc_last=1; o_busy low after o_frame_done.
REQ-042 i_ea=5, 3 writes then i_start with i_ea=1 and writes 1,2 -> only 1,2 output; no done pulse for the aborted frame.
REQ-043 With TURBO_ENC_SISO_BUF_WR_ERR_EN, a write in IDLE -> o_wr_err=1 and stays 1 until the next i_start; without the macro, the same stimulus gives unchanged outputs.
REQ-044 i_ea=4095 full-depth frame, then i_rst asserted mid-drain -> all outputs at reset values the next cycle, state IDLE.
